// File: rtl/bit_demux1x8_deser.sv
// Serial-to-parallel collector: scatters accepted bits into an 8-bit word with a valid/ready output.
// Optional build macro DESER_MSB_FIRST_EN places the k-th accepted bit at out_word[7-k] instead of out_word[k].
module bit_demux1x8_deser #(
   parameter logic [7:0] OUT_RESET = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_bit,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       clear,
   output logic [7:0] out_word,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [2:0] bit_count
);

   localparam int unsigned W    = 8;
   localparam int unsigned CW   = 3;
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   logic [W-2:0] stage;
   logic         stall_c;
   logic         accept_c;
   logic         done_c;
   logic         consume_c;
   logic [W-1:0] word_c;

   // Only the 8th bit can stall: it needs the output register to be free.
   assign stall_c   = (bit_count == LAST) & out_valid & ~out_ready;
   assign in_ready  = ~reset & ~clear & ~stall_c;
   assign accept_c  = in_valid & in_ready;
   assign done_c    = accept_c & (bit_count == LAST);
   assign consume_c = out_valid & out_ready;

   always_comb begin
      word_c = '0;
`ifdef DESER_MSB_FIRST_EN
      for (int k = 0; k < int'(W) - 1; k++) begin
         word_c[int'(W) - 1 - k] = stage[k];
      end
      word_c[0] = in_bit;
`else
      word_c = {in_bit, stage};
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bit_count <= '0;
         stage     <= '0;
         out_word  <= OUT_RESET;
         out_valid <= 1'b0;
      end else begin
         if (clear) begin
            bit_count <= '0;
            stage     <= '0;
         end else if (accept_c) begin
            if (bit_count == LAST) begin
               bit_count <= '0;
            end else begin
               stage[bit_count] <= in_bit;
               bit_count        <= bit_count + CW'(1);
            end
         end
         // Completion wins over consume so back-to-back words have no bubble.
         if (done_c) begin
            out_word  <= word_c;
            out_valid <= 1'b1;
         end else if (consume_c) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bit_demux1x8_deser.sv
// Directed and randomized bench for bit_demux1x8_deser against a bit-list reference model.
module tb_bit_demux1x8_deser;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_bit;
   logic       in_valid;
   logic       in_ready;
   logic       clear;
   logic [7:0] out_word;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] bit_count;

   localparam logic [7:0] RST_WORD = 8'h00;

   bit_demux1x8_deser #(.OUT_RESET(RST_WORD)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_bit    (in_bit),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .clear     (clear),
      .out_word  (out_word),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .bit_count (bit_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: list of bits collected so far plus the held output word.
   bit         m_bits[$];
   logic [7:0] m_word;
   bit         m_valid;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] build_word(input bit b[$]);
      logic [7:0] w = 8'h00;
      for (int k = 0; k < 8; k++) begin
`ifdef DESER_MSB_FIRST_EN
         if (b[k]) w = w + 8'(1 << (7 - k));
`else
         if (b[k]) w = w + 8'(1 << k);
`endif
      end
      return w;
   endfunction

   function automatic bit model_ready(input bit r, input bit clr, input bit ordy);
      return !r && !clr && !(m_bits.size() == 7 && m_valid && !ordy);
   endfunction

   // One clock: drive inputs, check outputs against the model, then advance the model.
   task automatic cyc(input bit r, input bit clr, input bit iv, input bit ib, input bit ordy);
      bit acc, done;
      reset = r; clear = clr; in_valid = iv; in_bit = ib; out_ready = ordy;
      #2;
      check("in_ready",  32'(in_ready),  32'(model_ready(r, clr, ordy)));
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("bit_count", 32'(bit_count), 32'(m_bits.size()));
      check("out_word",  32'(out_word),  32'(m_word));
      @(posedge clk);
      #1;
      if (r) begin
         m_bits.delete();
         m_word  = RST_WORD;
         m_valid = 1'b0;
      end else begin
         acc  = iv && model_ready(r, clr, ordy);
         done = 1'b0;
         if (clr) m_bits.delete();
         else if (acc) begin
            m_bits.push_back(ib);
            if (m_bits.size() == 8) begin
               m_word = build_word(m_bits);
               m_bits.delete();
               done = 1'b1;
            end
         end
         if (done) m_valid = 1'b1;
         else if (m_valid && ordy) m_valid = 1'b0;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit ordy);
      logic [7:0] v;
      v = b;
      for (int k = 0; k < 8; k++) cyc(1'b0, 1'b0, 1'b1, v[k], ordy);
   endtask

   initial begin
      reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
      m_word = RST_WORD; m_valid = 1'b0;
      @(posedge clk);
      #1;
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Stream 1,0,1,0,0,1,1,0 with consumer ready.
      send_byte(8'b0110_0101, 1'b1);
`ifdef DESER_MSB_FIRST_EN
      check("stream_word", 32'(out_word), 32'h A6);
`else
      check("stream_word", 32'(out_word), 32'h 65);
`endif
      check("stream_valid", 32'(out_valid), 32'd1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("stream_valid_drop", 32'(out_valid), 32'd0);

      // Backpressure: 16 ones with consumer stalled, then release.
      for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      check("bp_count", 32'(bit_count), 32'd7);
      check("bp_stall", 32'(in_ready), 32'd0);
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      check("bp_word", 32'(out_word), 32'h FF);
      check("bp_valid", 32'(out_valid), 32'd1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Back-to-back words.
      send_byte(8'h0F, 1'b1);
      send_byte(8'hF0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Clear at bit_count 3 with a pending word held.
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      check("clr_count", 32'(bit_count), 32'd0);
      send_byte(8'h00, 1'b1);
      check("clr_word", 32'(out_word), 32'h00);

      // Reset in the middle of a word.
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      check("rst_word", 32'(out_word), 32'(RST_WORD));
      check("rst_valid", 32'(out_valid), 32'd0);
      send_byte(8'h3C, 1'b0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 49) == 0),
             ($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 2) != 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
